// File: rtl/frame_config_ctrl.sv
// Column configuration frame controller: assembles NumRows words into FrameData, then pulses one FrameStrobe line.
// Optional build macro FRAME_CFG_COUNT_EN adds the frames_written output counter.
module frame_config_ctrl #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               MODE,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [FrameBitsPerRow-1:0]         s_data,
  input  logic [4:0]                         s_frame,
  input  logic                               err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               done,
  output logic                               err
`ifdef FRAME_CFG_COUNT_EN
  ,
  output logic [15:0]                        frames_written
`endif
);

  localparam int CW  = $clog2(NumRows) + 1;
  localparam int SCW = $clog2(StrobeCycles) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]                         r_state;
  logic [CW-1:0]                      r_cnt;
  logic [SCW-1:0]                     r_scnt;
  logic [4:0]                         r_frame;
  logic [NumRows*FrameBitsPerRow-1:0] r_frame_data;
  logic [MaxFramesPerCol-1:0]         r_strobe;
  logic                               r_done;
  logic                               r_err;
`ifdef FRAME_CFG_COUNT_EN
  logic                               r_frame_ok;
  logic [15:0]                        r_frames_written;
`endif

  logic                       w_xfer;
  logic [CW-1:0]              w_wr_row;
  logic                       w_last;
  logic [4:0]                 w_frame_sel;
  logic                       w_frame_ok;
  logic [MaxFramesPerCol-1:0] w_onehot;

  // s_ready is combinational so a MODE drop blocks the transfer in the same cycle.
  assign s_ready     = ~RESET & MODE & ((r_state == IDLE) | (r_state == LOAD));
  assign w_xfer      = s_valid & s_ready;
  assign w_wr_row    = (r_state == IDLE) ? {CW{1'b0}} : r_cnt;
  assign w_last      = (w_wr_row == CW'(NumRows - 1));
  assign w_frame_sel = (r_state == IDLE) ? s_frame : r_frame;
  assign w_frame_ok  = (32'(w_frame_sel) < MaxFramesPerCol);

  // One-hot decode of the frame index; out-of-range indices decode to all zeros.
  always_comb begin
    w_onehot = {MaxFramesPerCol{1'b0}};
    for (int f = 0; f < MaxFramesPerCol; f++) begin
      if (32'(w_frame_sel) == f) begin
        w_onehot[f] = 1'b1;
      end else begin
        w_onehot[f] = 1'b0;
      end
    end
  end

  // Frame sequencing, row capture, strobe timing and sticky error.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_cnt        <= {CW{1'b0}};
      r_scnt       <= {SCW{1'b0}};
      r_frame      <= 5'd0;
      r_frame_data <= {(NumRows*FrameBitsPerRow){1'b0}};
      r_strobe     <= {MaxFramesPerCol{1'b0}};
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef FRAME_CFG_COUNT_EN
      r_frame_ok       <= 1'b0;
      r_frames_written <= 16'd0;
`endif
    end else begin
      r_done <= 1'b0;
      if (err_clr) begin
        r_err <= 1'b0;
      end
      for (int r = 0; r < NumRows; r++) begin
        if (w_xfer && (w_wr_row == CW'(r))) begin
          r_frame_data[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
        end
      end
      // The last word of a frame arms the strobe; a later error set overrides err_clr above.
      if (w_xfer && w_last) begin
        r_state  <= STROBE;
        r_cnt    <= {CW{1'b0}};
        r_scnt   <= {SCW{1'b0}};
        r_strobe <= w_onehot;
        if (!w_frame_ok) begin
          r_err <= 1'b1;
        end
`ifdef FRAME_CFG_COUNT_EN
        r_frame_ok <= w_frame_ok;
`endif
      end
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_frame <= s_frame;
            if (!w_last) begin
              r_cnt   <= CW'(1);
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (!MODE) begin
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
          end else if (w_xfer && !w_last) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STROBE: begin
          if (!MODE || (r_scnt == SCW'(StrobeCycles - 1))) begin
            r_strobe <= {MaxFramesPerCol{1'b0}};
            r_state  <= GAP;
            r_done   <= 1'b1;
`ifdef FRAME_CFG_COUNT_EN
            if (r_frame_ok && (r_frames_written != 16'hFFFF)) begin
              r_frames_written <= r_frames_written + 16'd1;
            end
`endif
          end else begin
            r_scnt <= r_scnt + SCW'(1);
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_strobe <= {MaxFramesPerCol{1'b0}};
        end
      endcase
    end
  end

  assign FrameData   = r_frame_data;
  assign FrameStrobe = r_strobe;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign err         = r_err;
`ifdef FRAME_CFG_COUNT_EN
  assign frames_written = r_frames_written;
`endif

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Self-checking bench for frame_config_ctrl: vector table, directed corner sequences, random stream vs frame-level model.
module tb_frame_config_ctrl;

  logic         CLK;
  logic         RESET;
  logic         MODE;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic [4:0]   s_frame;
  logic         err_clr;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy;
  logic         done;
  logic         err;
`ifdef FRAME_CFG_COUNT_EN
  logic [15:0]  frames_written;
`endif

  int total = 0;
  int bad   = 0;

  frame_config_ctrl dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_frame(s_frame),
    .err_clr(err_clr), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .done(done), .err(err)
`ifdef FRAME_CFG_COUNT_EN
    , .frames_written(frames_written)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic         valid;
    logic [31:0]  data;
    logic [4:0]   frame;
    logic         exp_ready;
    logic [19:0]  exp_strobe;
    logic         exp_done;
    logic         exp_busy;
    logic [127:0] exp_fd;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Offer one word and wait (bounded) until it is taken; returns at the negedge after the accepting edge.
  task automatic push(input logic [31:0] d, input logic [4:0] f);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_frame = f;
    #1;
    while (!s_ready && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!s_ready) begin
      chk("push_timeout", 128'd0, 128'd1);
    end
    @(posedge CLK);
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  logic [31:0]  wd [4];
  logic [127:0] f1;
  logic [127:0] f2;

  // frame-level reference model state for the random section
  logic [31:0]  m_rows [4];
  int           m_wc;
  logic [4:0]   m_frame;
  logic         m_err;
  int           m_lo, m_hi, m_done_c;
  logic [19:0]  m_val;
  logic         m_done_ok;
  int           m_cnt;
  logic         xfer, inval;
  logic [19:0]  ev;

  initial begin
    RESET = 1'b1; MODE = 1'b1; s_valid = 1'b1; s_data = 32'h0; s_frame = 5'd0; err_clr = 1'b0;
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    f1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    f2 = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};

    tbl[0]  = '{1'b1, 32'h11111111, 5'd7, 1'b1, 20'h0, 1'b0, 1'b0, 128'h0};
    tbl[1]  = '{1'b1, 32'h22222222, 5'd7, 1'b1, 20'h0, 1'b0, 1'b1, {96'h0, 32'h11111111}};
    tbl[2]  = '{1'b1, 32'h33333333, 5'd7, 1'b1, 20'h0, 1'b0, 1'b1, {64'h0, 32'h22222222, 32'h11111111}};
    tbl[3]  = '{1'b1, 32'h44444444, 5'd7, 1'b1, 20'h0, 1'b0, 1'b1, {32'h0, 32'h33333333, 32'h22222222, 32'h11111111}};
    tbl[4]  = '{1'b1, 32'hAAAAAAAA, 5'd3, 1'b0, 20'h00080, 1'b0, 1'b1, f1};
    tbl[5]  = '{1'b1, 32'hAAAAAAAA, 5'd3, 1'b0, 20'h00080, 1'b0, 1'b1, f1};
    tbl[6]  = '{1'b1, 32'hAAAAAAAA, 5'd3, 1'b0, 20'h0, 1'b1, 1'b1, f1};
    tbl[7]  = '{1'b1, 32'hAAAAAAAA, 5'd3, 1'b1, 20'h0, 1'b0, 1'b0, f1};
    tbl[8]  = '{1'b1, 32'hBBBBBBBB, 5'd9, 1'b1, 20'h0, 1'b0, 1'b1, {32'h44444444, 32'h33333333, 32'h22222222, 32'hAAAAAAAA}};
    tbl[9]  = '{1'b1, 32'hCCCCCCCC, 5'd9, 1'b1, 20'h0, 1'b0, 1'b1, {32'h44444444, 32'h33333333, 32'hBBBBBBBB, 32'hAAAAAAAA}};
    tbl[10] = '{1'b1, 32'hDDDDDDDD, 5'd9, 1'b1, 20'h0, 1'b0, 1'b1, {32'h44444444, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}};
    tbl[11] = '{1'b0, 32'h0, 5'd0, 1'b0, 20'h00008, 1'b0, 1'b1, f2};
    tbl[12] = '{1'b0, 32'h0, 5'd0, 1'b0, 20'h00008, 1'b0, 1'b1, f2};
    tbl[13] = '{1'b0, 32'h0, 5'd0, 1'b0, 20'h0, 1'b1, 1'b1, f2};
    tbl[14] = '{1'b0, 32'h0, 5'd0, 1'b1, 20'h0, 1'b0, 1'b0, f2};

    // reset held for three cycles with MODE and s_valid high
    repeat (3) begin
      @(negedge CLK);
      chk("rst_ready", {127'd0, s_ready}, 128'd0);
      chk("rst_fd", FrameData, 128'd0);
      chk("rst_strobe", {108'd0, FrameStrobe}, 128'd0);
      chk("rst_busy_done_err", {125'd0, busy, done, err}, 128'd0);
    end
    RESET = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("rst_release_ready", {127'd0, s_ready}, 128'd1);

    // basic frame, back-to-back second frame, partial row overwrite
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      MODE = 1'b1;
      s_valid = tbl[i].valid;
      s_data  = tbl[i].data;
      s_frame = tbl[i].frame;
      #1;
      chk($sformatf("tbl%0d_ready", i), {127'd0, s_ready}, {127'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_strobe", i), {108'd0, FrameStrobe}, {108'd0, tbl[i].exp_strobe});
      chk($sformatf("tbl%0d_done", i), {127'd0, done}, {127'd0, tbl[i].exp_done});
      chk($sformatf("tbl%0d_busy", i), {127'd0, busy}, {127'd0, tbl[i].exp_busy});
      chk($sformatf("tbl%0d_fd", i), FrameData, tbl[i].exp_fd);
    end
    chk("tbl_err", {127'd0, err}, 128'd0);

    // stalled source: three idle cycles between words
    @(negedge CLK);
    for (int w = 0; w < 4; w++) begin
      push(wd[w], 5'd7);
      if (w < 3) begin
        for (int k = 0; k < 3; k++) begin
          chk("stall_no_strobe", {108'd0, FrameStrobe}, 128'd0);
          chk("stall_busy", {127'd0, busy}, 128'd1);
          @(negedge CLK);
        end
      end
    end
    chk("stall_strobe1", {108'd0, FrameStrobe}, {108'd0, 20'h00080});
    @(negedge CLK);
    chk("stall_strobe2", {108'd0, FrameStrobe}, {108'd0, 20'h00080});
    @(negedge CLK);
    chk("stall_strobe_off", {108'd0, FrameStrobe}, 128'd0);
    chk("stall_done", {127'd0, done}, 128'd1);
    chk("stall_fd", FrameData, f1);
    @(negedge CLK);
    chk("stall_done_once", {127'd0, done}, 128'd0);

    // invalid frame index, then err_clr, then frame 0
    for (int w = 0; w < 4; w++) push(32'hE0000000 + 32'(w), 5'd25);
    chk("inv_strobe1", {108'd0, FrameStrobe}, 128'd0);
    chk("inv_err", {127'd0, err}, 128'd1);
    @(negedge CLK);
    chk("inv_strobe2", {108'd0, FrameStrobe}, 128'd0);
    @(negedge CLK);
    chk("inv_done", {127'd0, done}, 128'd1);
    chk("inv_fd", FrameData, {32'hE0000003, 32'hE0000002, 32'hE0000001, 32'hE0000000});
    chk("inv_err_sticky", {127'd0, err}, 128'd1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    chk("inv_err_clr", {127'd0, err}, 128'd0);
    for (int w = 0; w < 4; w++) push(wd[w], 5'd0);
    chk("f0_strobe", {108'd0, FrameStrobe}, {108'd0, 20'h00001});
    repeat (3) @(negedge CLK);

    // MODE abort after two words
    push(32'h5A5A5A5A, 5'd5);
    push(32'hA5A5A5A5, 5'd5);
    MODE = 1'b0;
    s_valid = 1'b1;
    #1;
    chk("abort_ready_same_cycle", {127'd0, s_ready}, 128'd0);
    @(negedge CLK);
    s_valid = 1'b0;
    chk("abort_idle", {127'd0, busy}, 128'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", {127'd0, done}, 128'd0);
      chk("abort_no_strobe", {108'd0, FrameStrobe}, 128'd0);
      @(negedge CLK);
    end
    chk("abort_fd_kept", {64'd0, FrameData[63:0]}, {64'd0, 32'hA5A5A5A5, 32'h5A5A5A5A});
    MODE = 1'b1;
    for (int w = 0; w < 4; w++) push(wd[w], 5'd19);
    chk("f19_strobe1", {108'd0, FrameStrobe}, {108'd0, 20'h80000});
    @(negedge CLK);
    chk("f19_strobe2", {108'd0, FrameStrobe}, {108'd0, 20'h80000});
    @(negedge CLK);
    chk("f19_strobe_off", {108'd0, FrameStrobe}, 128'd0);
    chk("f19_done", {127'd0, done}, 128'd1);
    @(negedge CLK);

    // reset in the middle of a strobe
    for (int w = 0; w < 4; w++) push(wd[w], 5'd2);
    chk("midrst_strobe_before", {108'd0, FrameStrobe}, {108'd0, 20'h00004});
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_strobe", {108'd0, FrameStrobe}, 128'd0);
    chk("midrst_fd", FrameData, 128'd0);
    chk("midrst_busy_done", {126'd0, busy, done}, 128'd0);
    RESET = 1'b0;
`ifdef FRAME_CFG_COUNT_EN
    chk("midrst_count", {112'd0, frames_written}, 128'd0);
`endif

    // random stream against a frame-level model (MODE held at 1)
    for (int r = 0; r < 4; r++) m_rows[r] = 32'h0;
    m_wc = 0; m_frame = 5'd0; m_err = 1'b0;
    m_lo = -1; m_hi = -2; m_done_c = -1; m_val = 20'h0; m_done_ok = 1'b0; m_cnt = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge CLK);
      ev = (c >= m_lo && c <= m_hi) ? m_val : 20'h0;
      if (c == m_done_c && m_done_ok) m_cnt++;
      chk("rnd_ready", {127'd0, s_ready}, {127'd0, (c > m_done_c)});
      chk("rnd_strobe", {108'd0, FrameStrobe}, {108'd0, ev});
      chk("rnd_done", {127'd0, done}, {127'd0, (c == m_done_c)});
      chk("rnd_busy", {127'd0, busy}, {127'd0, (m_wc > 0) || (c <= m_done_c)});
      chk("rnd_err", {127'd0, err}, {127'd0, m_err});
      chk("rnd_fd", FrameData, {m_rows[3], m_rows[2], m_rows[1], m_rows[0]});
`ifdef FRAME_CFG_COUNT_EN
      chk("rnd_count", {112'd0, frames_written}, 128'(m_cnt));
`endif
      s_valid = ($urandom_range(0, 99) < 60);
      s_data  = $urandom;
      s_frame = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      err_clr = ($urandom_range(0, 19) == 0);
      xfer  = s_valid && (c > m_done_c);
      inval = 1'b0;
      if (xfer) begin
        m_rows[m_wc] = s_data;
        if (m_wc == 0) m_frame = s_frame;
        m_wc++;
        if (m_wc == 4) begin
          m_wc = 0;
          m_lo = c + 1;
          m_hi = c + 2;
          m_done_c = c + 3;
          m_done_ok = (m_frame < 5'd20);
          m_val = m_done_ok ? (20'd1 << m_frame) : 20'h0;
          inval = !m_done_ok;
        end
      end
      m_err = inval ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
    s_valid = 1'b0;
    err_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
